// File: rtl/bus_pkg.sv
// Shared types and address-range helpers for the CPU-to-peripheral interconnect.
// Range vectors pack {start,end} pairs per slave, slave 0 in the MSBs.
package bus_pkg;

  localparam int MAX_AW      = 32;
  localparam int MAX_RANGE_W = 1024;

  typedef logic [MAX_RANGE_W-1:0] range_vec_t;
  typedef logic [7:0]             slave_idx_t;

  localparam slave_idx_t UNMAPPED = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } bus_state_t;

  // Appends one {start,end} pair below the ones already present, so calling it
  // for slave 0 first leaves slave 0 in the MSBs.
  function automatic range_vec_t add_address(input range_vec_t         ranges,
                                             input int                 aw,
                                             input logic [MAX_AW-1:0]  start_addr,
                                             input logic [MAX_AW-1:0]  end_addr);
    range_vec_t mask;
    range_vec_t pair;
    mask = (range_vec_t'(1) << aw) - range_vec_t'(1);
    pair = ((range_vec_t'(start_addr) & mask) << aw) | (range_vec_t'(end_addr) & mask);
    return (ranges << (2 * aw)) | pair;
  endfunction

  function automatic logic [MAX_AW-1:0] get_address_start(input range_vec_t ranges,
                                                          input int         num,
                                                          input int         aw,
                                                          input int         idx);
    range_vec_t tmp;
    tmp = ranges >> ((num - 1 - idx) * 2 * aw + aw);
    return tmp[MAX_AW-1:0];
  endfunction

  function automatic logic [MAX_AW-1:0] get_address_end(input range_vec_t ranges,
                                                        input int         num,
                                                        input int         aw,
                                                        input int         idx);
    range_vec_t tmp;
    tmp = ranges >> ((num - 1 - idx) * 2 * aw);
    return tmp[MAX_AW-1:0];
  endfunction

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational address range match with lowest-index-wins priority encode.
// Produces the one-hot select, the winning index and an unmapped flag.
module bus_addr_decode
  import bus_pkg::*;
#(
  parameter int                                 NUM_SLAVES   = 7,
  parameter int                                 ADDR_WIDTH   = 16,
  parameter logic [2*ADDR_WIDTH*NUM_SLAVES-1:0] SLAVE_RANGES = '0
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [NUM_SLAVES-1:0] sel_onehot,
  output slave_idx_t            sel_idx,
  output logic                  unmapped
);

  logic [NUM_SLAVES-1:0] hit;
  logic [NUM_SLAVES:0]   taken;
  slave_idx_t            idx_chain [NUM_SLAVES+1];

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a,
                                    input logic [ADDR_WIDTH-1:0] lo,
                                    input logic [ADDR_WIDTH-1:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

  assign taken[0]     = 1'b0;
  assign idx_chain[0] = UNMAPPED;

  // Walking up from slave 0, a hit only wins if no lower slave already hit.
  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_slave
    localparam logic [ADDR_WIDTH-1:0] RANGE_START =
      ADDR_WIDTH'(get_address_start(range_vec_t'(SLAVE_RANGES), NUM_SLAVES, ADDR_WIDTH, i));
    localparam logic [ADDR_WIDTH-1:0] RANGE_END =
      ADDR_WIDTH'(get_address_end(range_vec_t'(SLAVE_RANGES), NUM_SLAVES, ADDR_WIDTH, i));

    assign hit[i]         = in_range(addr, RANGE_START, RANGE_END);
    assign sel_onehot[i]  = hit[i] & ~taken[i];
    assign taken[i+1]     = taken[i] | hit[i];
    assign idx_chain[i+1] = sel_onehot[i] ? slave_idx_t'(i) : idx_chain[i];
  end

  assign sel_idx  = idx_chain[NUM_SLAVES];
  assign unmapped = ~taken[NUM_SLAVES];

endmodule

// File: rtl/bus_interconnect.sv
// CPU-to-peripheral interconnect: range decode, registered read mux, ack handshake
// with timeout and unmapped-address errors. Define BUS_STATS_EN for error statistics.
module bus_interconnect
  import bus_pkg::*;
#(
  parameter int                                 NUM_SLAVES      = 7,
  parameter int                                 ADDR_WIDTH      = 16,
  parameter int                                 DATA_WIDTH      = 8,
  parameter logic [2*ADDR_WIDTH*NUM_SLAVES-1:0] SLAVE_RANGES    = '0,
  parameter logic [NUM_SLAVES-1:0]              SLAVE_WAIT_MASK = '0,
  parameter int                                 TIMEOUT_CYCLES  = 15,
  parameter logic [DATA_WIDTH-1:0]              DEFAULT_DATA    = {DATA_WIDTH{1'b1}}
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [ADDR_WIDTH-1:0]           cpu_addr_i,
  input  logic [DATA_WIDTH-1:0]           cpu_data_i,
  input  logic                            cpu_we_i,
  output logic [DATA_WIDTH-1:0]           cpu_data_o,
  output logic                            cpu_rdy_o,
  output logic [NUM_SLAVES-1:0]           slv_sel_o,
  output logic [ADDR_WIDTH-1:0]           slv_addr_o,
  output logic [DATA_WIDTH-1:0]           slv_data_o,
  output logic                            slv_we_o,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] slv_data_i,
  input  logic [NUM_SLAVES-1:0]           slv_ack_i,
  output logic                            err_o
`ifdef BUS_STATS_EN
  ,
  output logic [7:0]                      err_count_o,
  output logic [ADDR_WIDTH-1:0]           err_addr_o
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [NUM_SLAVES-1:0] dec_sel;
  slave_idx_t            dec_idx;
  logic                  dec_unmapped;
  logic                  dec_wait;
  logic                  ack_hit;

  bus_state_t            state_q, state_d;
  slave_idx_t            sel_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  timeout;

  // Slave i read data lives at slv_data_i[i*DATA_WIDTH +: DATA_WIDTH].
  logic [NUM_SLAVES:0][DATA_WIDTH-1:0] ack_chain;
  logic [NUM_SLAVES:0][DATA_WIDTH-1:0] rd_chain;

  bus_addr_decode #(
    .NUM_SLAVES  (NUM_SLAVES),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .SLAVE_RANGES(SLAVE_RANGES)
  ) u_decode (
    .addr      (cpu_addr_i),
    .sel_onehot(dec_sel),
    .sel_idx   (dec_idx),
    .unmapped  (dec_unmapped)
  );

  assign slv_sel_o  = dec_sel;
  assign slv_addr_o = cpu_addr_i;
  assign slv_data_o = cpu_data_i;
  assign slv_we_o   = cpu_we_i;

  assign dec_wait = |(dec_sel & SLAVE_WAIT_MASK);
  assign ack_hit  = |(dec_sel & SLAVE_WAIT_MASK & slv_ack_i);

  assign ack_chain[0] = '0;
  assign rd_chain[0]  = '0;

  // AND-OR muxes: ack capture follows the live decode, read data follows sel_q.
  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_mux
    logic [DATA_WIDTH-1:0] slv_rd;
    logic [DATA_WIDTH-1:0] slv_out;
    assign slv_rd         = slv_data_i[i*DATA_WIDTH +: DATA_WIDTH];
    assign slv_out        = SLAVE_WAIT_MASK[i] ? hold_q : slv_rd;
    assign ack_chain[i+1] = ack_chain[i] | ({DATA_WIDTH{dec_sel[i]}} & slv_rd);
    assign rd_chain[i+1]  = rd_chain[i]
                          | ({DATA_WIDTH{sel_q == slave_idx_t'(i)}} & slv_out);
  end

  assign cpu_data_o = (sel_q == UNMAPPED) ? DEFAULT_DATA : rd_chain[NUM_SLAVES];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    cpu_rdy_o = 1'b1;
    timeout   = 1'b0;
    case (state_q)
      IDLE: begin
        if (dec_wait) begin
          cpu_rdy_o = 1'b0;
          cnt_d     = '0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        cpu_rdy_o = 1'b0;
        cnt_d     = cnt_q + CNT_W'(1);
        if (ack_hit) begin
          hold_d  = ack_chain[NUM_SLAVES];
          state_d = DONE;
        end else if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
          hold_d  = DEFAULT_DATA;
          timeout = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign err_o = (cpu_rdy_o & dec_unmapped) | timeout;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= DEFAULT_DATA;
      sel_q   <= UNMAPPED;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      if (cpu_rdy_o) sel_q <= dec_idx;
    end
  end

`ifdef BUS_STATS_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      err_count_o <= '0;
      err_addr_o  <= '0;
    end else if (err_o) begin
      if (err_count_o != 8'hFF) err_count_o <= err_count_o + 8'd1;
      err_addr_o <= cpu_addr_i;
    end
  end
`endif

endmodule

// File: tb/tb_bus_interconnect.sv
// Directed self-checking bench for bus_interconnect (7 slaves, slaves 2 and 4 wait).
module tb_bus_interconnect;
  import bus_pkg::*;

  localparam logic [223:0] RANGES = {
    16'h0000, 16'h1FFF,   // s0
    16'h8000, 16'h9FFF,   // s1
    16'h4000, 16'h4FFF,   // s2 wait
    16'h9000, 16'h93FF,   // s3 overlaps s1
    16'h2000, 16'h2FFF,   // s4 wait
    16'h3000, 16'h3FFF,   // s5
    16'hC000, 16'hFFFF    // s6
  };

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic [7:0]  cpu_rdata;
  logic        cpu_rdy;
  logic [6:0]  slv_sel;
  logic [15:0] slv_addr;
  logic [7:0]  slv_wdata;
  logic        slv_we;
  logic [7:0]  slv_rd [7];
  logic [55:0] slv_rdata;
  logic [6:0]  slv_ack;
  logic        err;
`ifdef BUS_STATS_EN
  logic [7:0]  err_count;
  logic [15:0] err_addr;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  assign slv_rdata = {slv_rd[6], slv_rd[5], slv_rd[4], slv_rd[3],
                      slv_rd[2], slv_rd[1], slv_rd[0]};

  always #5 clk_i = ~clk_i;

  bus_interconnect #(
    .NUM_SLAVES     (7),
    .ADDR_WIDTH     (16),
    .DATA_WIDTH     (8),
    .SLAVE_RANGES   (RANGES),
    .SLAVE_WAIT_MASK(7'b0010100),
    .TIMEOUT_CYCLES (15),
    .DEFAULT_DATA   (8'hFF)
  ) dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .cpu_addr_i(cpu_addr),
    .cpu_data_i(cpu_wdata),
    .cpu_we_i  (cpu_we),
    .cpu_data_o(cpu_rdata),
    .cpu_rdy_o (cpu_rdy),
    .slv_sel_o (slv_sel),
    .slv_addr_o(slv_addr),
    .slv_data_o(slv_wdata),
    .slv_we_o  (slv_we),
    .slv_data_i(slv_rdata),
    .slv_ack_i (slv_ack),
    .err_o     (err)
`ifdef BUS_STATS_EN
    ,
    .err_count_o(err_count),
    .err_addr_o (err_addr)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int low;
    int errs;
    logic done;
    logic [15:0] b_addr [5];
    logic [6:0]  b_sel  [5];
    logic        b_err  [5];

    b_addr = '{16'h1FFF, 16'h93FF, 16'h3FFF, 16'hFFFF, 16'h5000};
    b_sel  = '{7'b0000001, 7'b0000010, 7'b0100000, 7'b1000000, 7'b0000000};
    b_err  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    reset_i   = 1'b1;
    cpu_addr  = 16'h0000;
    cpu_wdata = 8'h00;
    cpu_we    = 1'b0;
    slv_ack   = 7'b0;
    slv_rd[0] = 8'hA9; slv_rd[1] = 8'h11; slv_rd[2] = 8'h5C; slv_rd[3] = 8'h33;
    slv_rd[4] = 8'h44; slv_rd[5] = 8'h55; slv_rd[6] = 8'h66;

    tick(); tick(); #1;
    chk("rst_rdy",  32'(cpu_rdy),   32'd1);
    chk("rst_err",  32'(err),       32'd0);
    chk("rst_data", 32'(cpu_rdata), 32'hFF);
    reset_i = 1'b0;

    // Non-wait read from slave 0
    cpu_addr = 16'h0200; #1;
    chk("nw_sel", 32'(slv_sel), 32'b0000001);
    chk("nw_rdy", 32'(cpu_rdy), 32'd1);
    chk("nw_err", 32'(err),     32'd0);
    tick(); #1;
    chk("nw_data",     32'(cpu_rdata), 32'hA9);
    chk("nw_rdy_next", 32'(cpu_rdy),   32'd1);

    // Wait slave 2, ack in the third stalled cycle
    cpu_addr = 16'h4000;
    low = 0; errs = 0; done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      slv_ack = (k == 2) ? 7'b0000100 : 7'b0000000;
      #1;
      if (err) errs++;
      if (cpu_rdy) done = 1'b1;
      else begin
        low++;
        tick();
      end
    end
    chk("wait_low",  32'(low),  32'd3);
    chk("wait_err",  32'(errs), 32'd0);
    tick(); #1;
    chk("wait_data", 32'(cpu_rdata), 32'h5C);

    // Same wait slave, never acks: timeout
    low = 0; errs = 0; done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      #1;
      if (err) errs++;
      if (cpu_rdy) done = 1'b1;
      else begin
        low++;
        tick();
      end
    end
    chk("to_low",  32'(low),  32'd16);
    chk("to_errs", 32'(errs), 32'd1);
    tick(); #1;
    chk("to_data", 32'(cpu_rdata), 32'hFF);
    cpu_addr = 16'h0000; #1;
    chk("after_to_rdy", 32'(cpu_rdy), 32'd1);
    tick(); #1;
    chk("after_to_data", 32'(cpu_rdata), 32'hA9);

    // Unmapped read then unmapped write
    cpu_addr = 16'hA000; #1;
    chk("um_rd_err", 32'(err),     32'd1);
    chk("um_rd_sel", 32'(slv_sel), 32'd0);
    chk("um_rd_rdy", 32'(cpu_rdy), 32'd1);
    tick(); #1;
    chk("um_rd_data", 32'(cpu_rdata), 32'hFF);
    cpu_we = 1'b1; cpu_wdata = 8'h3C; #1;
    chk("um_wr_sel",   32'(slv_sel),   32'd0);
    chk("um_wr_err",   32'(err),       32'd1);
    chk("um_wr_we",    32'(slv_we),    32'd1);
    chk("um_wr_wdata", 32'(slv_wdata), 32'h3C);
    chk("um_wr_addr",  32'(slv_addr),  32'hA000);
    tick();
    cpu_we = 1'b0;

    // Overlap: slaves 1 and 3 both cover 0x9000
    cpu_addr = 16'h9000; #1;
    chk("ovl_sel", 32'(slv_sel), 32'b0000010);
    tick(); #1;
    chk("ovl_data", 32'(cpu_rdata), 32'h11);

    // Range boundaries
    for (int i = 0; i < 5; i++) begin
      cpu_addr = b_addr[i]; #1;
      chk($sformatf("bnd_sel_%04h", b_addr[i]), 32'(slv_sel), 32'(b_sel[i]));
      chk($sformatf("bnd_err_%04h", b_addr[i]), 32'(err),     32'(b_err[i]));
    end
    cpu_addr = 16'hFFFF;
    tick(); #1;
    chk("bnd_data_ffff", 32'(cpu_rdata), 32'h66);

    // Reset during WAIT on slave 4, then a late ack
    cpu_addr = 16'h2000; #1;
    chk("rw_stall", 32'(cpu_rdy), 32'd0);
    tick();
    reset_i  = 1'b1;
    cpu_addr = 16'h0000;
    tick();
    reset_i = 1'b0;
    slv_ack = 7'b0010000; #1;
    chk("rw_rdy", 32'(cpu_rdy), 32'd1);
    chk("rw_err", 32'(err),     32'd0);
    tick();
    slv_ack = 7'b0; #1;
    chk("rw_rdy2", 32'(cpu_rdy),   32'd1);
    chk("rw_err2", 32'(err),       32'd0);
    chk("rw_data", 32'(cpu_rdata), 32'hA9);

`ifdef BUS_STATS_EN
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0; #1;
    chk("st_cnt_rst",  32'(err_count), 32'd0);
    chk("st_addr_rst", 32'(err_addr),  32'd0);
    cpu_addr = 16'h5000;
    repeat (300) tick();
    #1;
    chk("st_cnt_sat", 32'(err_count), 32'd255);
    chk("st_addr",    32'(err_addr),  32'h5000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
